fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the RV32 core, directly upstream of the controller/decode stage. Maintains the fetch PC, issues word requests to instruction memory over a valid/ready handshake, buffers in-order responses with their PCs in a small FIFO, and presents them to decode over a valid/ready handshake. Branch, jal and jalr redirects from downstream flush the buffer and discard stale in-flight responses.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset
- DEPTH, 4, FIFO entries; power of two, ≥2; DEPTH≥3 required for 1 instr/cycle with 1-cycle memory
- clk  in  1  clock, all state on posedge
- rst  in  1  reset; synchronous and active-high
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word address of request, bits [1:0] always 0
- imem_resp_valid  in  1  response valid; one per accepted request, in order, ≥1 cycle after accept, no backpressure
- imem_resp_data  in  32  instruction word
- redirect_valid  in  1  redirect from branch/jump unit
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored (treated as 0)
- instr_valid  out  1  instruction available to decode
- instr_ready  in  1  decode consumes instruction
- instr  out  32  instruction word
- instr_pc  out  32  PC of `instr`

## Operation
- State: fetch_pc (32), FIFO of {pc, instr} × DEPTH, count, outstanding (requests accepted, response not yet seen; width clog2(2·DEPTH+1)), drop (stale responses still to discard).
- live = outstanding − drop. Issue condition: live + count < DEPTH, outstanding < 2·DEPTH, redirect_valid low.
- imem_req_valid = issue condition (never depends on imem_req_ready); imem_req_addr = fetch_pc.
- Request accept (valid & ready): fetch_pc ← fetch_pc + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0); outstanding +1.
- Response: outstanding −1. If drop > 0: drop −1, data discarded. Else push {pc, data}; pc is tracked via a resp_pc register that advances +4 per pushed response and is loaded with the target on redirect/reset.
- Decode side: instr_valid = (count > 0) & ~redirect_valid; instr/instr_pc = FIFO head; pop on instr_valid & instr_ready.
- Redirect cycle: FIFO flushed (count ← 0), no issue, no pop; fetch_pc ← {redirect_pc[31:2],2'b0}; resp_pc ← same; drop ← outstanding − imem_resp_valid; a response arriving this cycle is discarded.
- FIFO never overflows by construction; an over-push is a design error (bench asserts).
- Back-to-back redirects: each one reloads PC and recomputes drop; the latest wins.

## Timing
- Reset (rst high at edge): fetch_pc = RESET_PC, count = outstanding = drop = 0. During reset cycle and reset value: imem_req_valid = 0, instr_valid = 0, imem_req_addr = RESET_PC, instr/instr_pc = 0.
- First cycle after rst deasserts: imem_req_valid = 1, addr = RESET_PC.
- Latency: request accept at T, response at T+k (k≥1), instr_valid at T+k+1 (no bypass of the FIFO).
- Redirect at T: first request to new PC at T+1; first valid instr from it no earlier than T+3 (1-cycle memory).
- rst mid-operation: all state cleared; responses to pre-reset requests are environment's responsibility (memory must be reset too).
- Simultaneous response + pop on full FIFO: legal, count unchanged. Simultaneous accept + response: outstanding unchanged.

## Test plan
- Reset, RESET_PC=0x100, ready=1, 1-cycle memory, instr_ready=1 -> addrs 0x100,0x104,0x108… every cycle; instr_pc 0x100 at cycle 3, then one instr per cycle, data matches.
- instr_ready=0 for 10 cycles -> exactly DEPTH=4 requests issued, FIFO full, imem_req_valid low; release -> 4 instrs in order 0x100..0x10C, fetching resumes at 0x110.
- 3 requests in flight with 4-cycle memory, redirect_pc=0x2003 -> 3 stale responses discarded, next instr_pc = 0x2000, no stale instr ever visible.
- Redirect in same cycle as a response and as instr_valid & instr_ready -> no pop counted, response discarded, drop = outstanding−1.
- fetch_pc at 0xFFFF_FFF8 -> addrs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 with matching instr_pc.
- Random imem_req_ready/instr_ready stalls and random redirects, 10k cycles -> scoreboard: instr_pc sequence equals model, no FIFO overflow, outstanding never exceeds 8.

Source files
------------

// File: rtl/fetch_unit.sv
// RV32 instruction fetch stage: keeps the fetch PC, issues word requests to imem,
// buffers in-order responses with their PCs and hands them to decode; redirects flush.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(2 * DEPTH + 1);

  localparam logic [OW:0]   DEPTH_L  = (OW + 1)'(DEPTH);
  localparam logic [OW-1:0] MAX_OUT  = OW'(2 * DEPTH);
  localparam logic [31:0]   BOOT_PC  = RESET_PC & 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  entry_t          fifo [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [OW-1:0]   outstanding, drop;
  logic [31:0]     fetch_pc, resp_pc;

  logic [OW-1:0]   live;
  logic [OW:0]     level;
  logic            issue, accept, pop, push, stale;
  logic [31:0]     target;

  // Live requests plus buffered entries must never exceed the FIFO, so every
  // response that is kept is guaranteed a free slot.
  always_comb begin
    live   = outstanding - drop;
    level  = (OW + 1)'(live) + (OW + 1)'(count);
    issue  = (level < DEPTH_L) && (outstanding < MAX_OUT) && !redirect_valid;
    target = redirect_pc & 32'hFFFF_FFFC;
  end

  assign imem_req_valid = issue & ~rst;
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid & imem_req_ready;

  assign instr_valid = (count != '0) & ~redirect_valid & ~rst;
  assign instr       = fifo[rd_ptr].data;
  assign instr_pc    = fifo[rd_ptr].pc;
  assign pop         = instr_valid & instr_ready;

  assign stale = (drop != '0);
  assign push  = imem_resp_valid & ~stale & ~redirect_valid & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= BOOT_PC;
      resp_pc     <= BOOT_PC;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight (minus what lands this cycle) is stale.
      fetch_pc    <= target;
      resp_pc     <= target;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      outstanding <= outstanding - OW'(imem_resp_valid);
      drop        <= outstanding - OW'(imem_resp_valid);
    end else begin
      if (accept) fetch_pc <= fetch_pc + 32'd4;
      outstanding <= outstanding + OW'(accept) - OW'(imem_resp_valid);
      if (imem_resp_valid && stale) drop <= drop - OW'(1);
      if (push) begin
        fifo[wr_ptr] <= '{pc: resp_pc, data: imem_resp_data};
        wr_ptr       <= wr_ptr + PW'(1);
        resp_pc      <= resp_pc + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and random checks of fetch_unit against an in-order imem model and a PC scoreboard.
module tb_fetch_unit;
  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam int          DEPTH = 4;

  logic        clk, rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;

  fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // imem model: in-order, per-request latency in [lat_min, lat_max]
  logic [31:0] mq_addr [$];
  int          mq_due  [$];
  int          cyc, last_due, lat_min, lat_max;
  logic [31:0] exp_pc;

  logic        acc, popped;
  logic [31:0] acc_addr, pop_pc;

  // One cycle, entered just after a negedge with inputs already set.
  task automatic step();
    int d;
    if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mdata(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
    #1;
    acc      = imem_req_valid & imem_req_ready;
    acc_addr = imem_req_addr;
    popped   = instr_valid & instr_ready;
    pop_pc   = instr_pc;
    if (redirect_valid) begin
      chk("redir_req_valid", imem_req_valid, 0);
      chk("redir_instr_valid", instr_valid, 0);
      exp_pc = redirect_pc & 32'hFFFF_FFFC;
    end else if (popped) begin
      chk("sb_pc", instr_pc, exp_pc);
      chk("sb_instr", instr, mdata(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end
    if (acc) begin
      d = cyc + int'($urandom_range(lat_max, lat_min));
      if (d <= last_due) d = last_due + 1;
      mq_addr.push_back(imem_req_addr);
      mq_due.push_back(d);
      last_due = d;
    end
    chk("outstanding_le8", (mq_addr.size() <= 2 * DEPTH), 1);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_resp_valid = 1'b0; imem_resp_data = '0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_addr", imem_req_addr, RPC);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mq_addr.delete(); mq_due.delete();
    cyc = 0; last_due = -1; exp_pc = RPC;
  endtask

  initial begin
    int n, k, got, npop;
    logic [31:0] fpc;
    logic [31:0] wexp [4];
    rst = 1'b1; imem_req_ready = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    imem_resp_valid = 1'b0; imem_resp_data = '0;
    lat_min = 1; lat_max = 1; cyc = 0; last_due = -1; exp_pc = RPC;
    repeat (2) @(negedge clk);

    // Streaming with 1-cycle memory
    do_reset();
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t1_acc", acc, 1);
      chk("t1_addr", acc_addr, RPC + 32'(4 * i));
      if (i >= 2) begin
        chk("t1_pop", popped, 1);
        chk("t1_pc", pop_pc, RPC + 32'(4 * (i - 2)));
      end else chk("t1_nopop", popped, 0);
    end

    // Decode stall fills the FIFO
    do_reset();
    instr_ready = 1'b0; n = 0;
    repeat (10) begin step(); n += int'(acc); end
    chk("t2_nreq", n, DEPTH);
    chk("t2_req_valid_full", imem_req_valid, 0);
    chk("t2_instr_valid", instr_valid, 1);
    instr_ready = 1'b1; k = 0; got = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (popped && k < 4) begin chk("t2_pc", pop_pc, RPC + 32'(4 * k)); k++; end
      if (acc && got == 0) begin got = 1; chk("t2_resume", acc_addr, RPC + 32'h10); end
    end
    chk("t2_npop", k, 4);
    chk("t2_resumed", got, 1);

    // Redirect with 3 requests in flight, 4-cycle memory
    do_reset();
    lat_min = 4; lat_max = 4;
    repeat (3) step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2003;
    step();
    chk("t3_no_acc", acc, 0);
    redirect_valid = 1'b0;
    step();
    chk("t3_acc", acc, 1);
    chk("t3_addr", acc_addr, 32'h0000_2000);
    got = 0; fpc = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (popped && got == 0) begin got = 1; fpc = pop_pc; end
    end
    chk("t3_seen", got, 1);
    chk("t3_first_pc", fpc, 32'h0000_2000);

    // Redirect coinciding with a response and a would-be pop, 2-cycle memory
    do_reset();
    lat_min = 2; lat_max = 2;
    repeat (6) step();
    chk("t4_pre_valid", instr_valid, 1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3000;
    step();
    chk("t4_nopop", popped, 0);
    redirect_valid = 1'b0;
    got = 0; fpc = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (popped && got == 0) begin got = 1; fpc = pop_pc; end
    end
    chk("t4_seen", got, 1);
    chk("t4_first_pc", fpc, 32'h0000_3000);

    // PC wrap at the top of the address space
    do_reset();
    lat_min = 1; lat_max = 1;
    wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0; wexp[3] = 32'h4;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0; n = 0; k = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (acc && n < 4) begin chk("t5_addr", acc_addr, wexp[n]); n++; end
      if (popped && k < 3) begin chk("t5_pc", pop_pc, wexp[k]); k++; end
    end
    chk("t5_nacc", n, 4);
    chk("t5_npop", k, 3);

    // Random stalls, latencies and redirects
    do_reset();
    lat_min = 1; lat_max = 4; npop = 0;
    for (int i = 0; i < 10000; i++) begin
      imem_req_ready = ($urandom_range(3, 0) != 0);
      instr_ready    = ($urandom_range(2, 0) != 0);
      redirect_valid = ($urandom_range(39, 0) == 0);
      redirect_pc    = $urandom;
      step();
      npop += int'(popped);
    end
    chk("t6_progress", (npop > 1000), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
